key_load_ctrl: RTL
==================

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles allowed in HAVE_LO without a second byte; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  reset, synchronous, active-low; clock clk.
REQ-004 byte_in  input  8  key byte from the provisioning source.
REQ-005 byte_valid  input  1  byte_in valid; a byte is accepted when byte_valid and byte_ready are both 1 at a rising edge.
REQ-006 byte_ready  output  1  controller can accept a byte this cycle.
REQ-007 commit  input  1  request to write the assembled word to the key store.
REQ-008 zeroize  input  1  request to overwrite the key store with zero.
REQ-009 lock_req  input  1  request to make the key store write-once until reset.
REQ-010 err_clr  input  1  clears the err flag.
REQ-011 key_out  output  16  registered word driven to the downstream key store data input.
REQ-012 key_we  output  1  registered one-cycle write strobe to the downstream key store.
REQ-013 locked  output  1  1 while in LOCKED.
REQ-014 busy  output  1  1 in HAVE_LO, FULL, or WRITE.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 States SHALL be IDLE, HAVE_LO, FULL, WRITE, LOCKED.
REQ-017 byte_ready SHALL be 1 in IDLE and HAVE_LO and 0 in all other states; it is a registered output, not a combinational function of byte_valid.
REQ-018 In IDLE, an accepted byte SHALL be stored as the low byte, and the state moves to HAVE_LO with the timer cleared to 0.
REQ-019 In HAVE_LO, an accepted byte SHALL be stored as the high byte, and the state moves to FULL.
REQ-020 In HAVE_LO, each cycle without an accepted byte SHALL increment the timer. When the timer reaches TIMEOUT-1 with no byte accepted, the low byte is cleared, err is set to 1, and the state returns to IDLE.
REQ-021 In FULL, commit=1 SHALL move the state to WRITE. Without commit, the controller stays in FULL indefinitely.
REQ-022 WRITE SHALL last exactly one cycle, with key_we=1 and key_out={high byte, low byte}.
REQ-023 On leaving WRITE, both stored bytes SHALL be cleared to 0, and the next state is IDLE.
REQ-024 Latency: commit sampled at edge N in FULL SHALL give key_we=1 in the cycle following edge N+1 (state WRITE).
REQ-025 lock_req=1 in IDLE SHALL move the state to LOCKED. In other non-LOCKED states, lock_req is held pending and takes effect on the next entry to IDLE.
REQ-026 LOCKED SHALL be left only by reset. In LOCKED:
- commit is ignored;
- byte_valid=1 sets err;
- key_we stays 0 except for zeroize.
REQ-027 zeroize=1 SHALL, in any state, produce key_out=0 and key_we=1 for exactly one cycle, starting the cycle after zeroize is sampled.
REQ-028 The same zeroize SHALL clear both stored bytes and the timer, then go to IDLE, or stay in LOCKED if already locked.
REQ-029 Priority per edge SHALL be, highest first: resetn, zeroize, timeout, commit / byte accept, lock_req.
REQ-030 A byte offered in the same cycle as zeroize SHALL NOT be accepted, even though byte_ready=1.
REQ-031 commit in IDLE or HAVE_LO SHALL set err and have no other effect.
REQ-032 err_clr=1 SHALL clear err, unless a new error event occurs in the same cycle; the set wins.
REQ-033 key_out SHALL hold its last value between writes, and key_we SHALL never be asserted on two consecutive cycles.

Reset
REQ-034 When resetn=0 at a rising edge, the block SHALL go to IDLE and set:
- byte_ready=1;
- key_out=16'h0000;
- key_we=0, locked=0, busy=0, err=0;
- both stored bytes, the timer, and pending lock cleared.
REQ-035 Reset SHALL take effect from any state, including mid-WRITE; no key_we pulse is emitted on the reset edge or after it.

Verification
REQ-036 Bytes 8'h34 then 8'h12 accepted, then commit -> one key_we pulse with key_out=16'h1234, then IDLE, byte_ready=1.
REQ-037 Byte 8'hAA accepted, then no byte for TIMEOUT cycles -> err=1, state IDLE; a following commit issues no key_we.
REQ-038 Load and commit 16'hBEEF, then lock_req -> locked=1. Then offer byte 8'h55 and commit -> no key_we, err=1, key_out stays 16'hBEEF.
REQ-039 In LOCKED with key_out=16'hBEEF, zeroize -> one key_we pulse with key_out=16'h0000, and locked stays 1.
REQ-040 In FULL with 16'h5A5A assembled, commit and zeroize in the same cycle -> a single key_we with key_out=16'h0000, then IDLE, stored bytes 0.
REQ-041 resetn=0 during WRITE of 16'hC0DE -> key_we=0 after the edge, key_out=16'h0000, locked=0, err=0.

Source files
------------

// File: rtl/key_load_ctrl_if.sv
// key_load_ctrl_if: byte load, command and key-store write signals of the key load controller.
interface key_load_ctrl_if;
  logic [7:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic commit;
  logic zeroize;
  logic lock_req;
  logic err_clr;
  logic [15:0] key_out;
  logic key_we;
  logic locked;
  logic busy;
  logic err;
  modport master (
    output byte_in, byte_valid, commit, zeroize, lock_req, err_clr,
    input byte_ready, key_out, key_we, locked, busy, err
  );
  modport slave (
    input byte_in, byte_valid, commit, zeroize, lock_req, err_clr,
    output byte_ready, key_out, key_we, locked, busy, err
  );
endinterface

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: assembles two key bytes into a 16-bit word and writes, zeroizes or locks the key store.
module key_load_ctrl #(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic resetn,
  key_load_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HAVE_LO, FULL, WRITE, LOCKED} state_t;
  state_t st, nst, to_idle;
  logic [7:0] lo, hi, tm, nlo, nhi, ntm;
  logic lock_pend, zpend, lp, acc, ev, wr, want_z;
  assign acc = bus.byte_valid & bus.byte_ready;
  assign lp = lock_pend | bus.lock_req;
  assign to_idle = lp ? LOCKED : IDLE;
  // A zeroize landing right after a strobe is deferred one cycle so key_we never pulses back to back.
  assign want_z = bus.zeroize | zpend;
  always_comb begin
    nst = st;
    nlo = lo;
    nhi = hi;
    ntm = tm;
    ev = 1'b0;
    wr = 1'b0;
    if (bus.zeroize) begin
      nlo = '0;
      nhi = '0;
      ntm = '0;
      nst = (st == LOCKED) ? LOCKED : to_idle;
    end else begin
      case (st)
        IDLE: begin
          ev = bus.commit;
          if (acc) begin
            nlo = bus.byte_in;
            ntm = '0;
            nst = HAVE_LO;
          end else if (lp) nst = LOCKED;
        end
        HAVE_LO: begin
          ev = bus.commit;
          if (tm == 8'(TIMEOUT - 1)) begin
            nlo = '0;
            ntm = '0;
            ev = 1'b1;
            nst = to_idle;
          end else if (acc) begin
            nhi = bus.byte_in;
            nst = FULL;
          end else ntm = tm + 8'd1;
        end
        FULL: nst = bus.commit ? WRITE : FULL;
        WRITE: begin
          wr = 1'b1;
          nlo = '0;
          nhi = '0;
          nst = to_idle;
        end
        default: ev = bus.byte_valid;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st <= IDLE;
      lo <= '0;
      hi <= '0;
      tm <= '0;
      lock_pend <= 1'b0;
      zpend <= 1'b0;
      bus.byte_ready <= 1'b1;
      bus.key_out <= '0;
      bus.key_we <= 1'b0;
      bus.locked <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      st <= nst;
      lo <= nlo;
      hi <= nhi;
      tm <= ntm;
      lock_pend <= (nst == LOCKED) ? 1'b0 : lp;
      zpend <= want_z & bus.key_we;
      bus.byte_ready <= nst == IDLE || nst == HAVE_LO;
      bus.busy <= nst == HAVE_LO || nst == FULL || nst == WRITE;
      bus.locked <= nst == LOCKED;
      bus.err <= ev | (bus.err & ~bus.err_clr);
      bus.key_we <= want_z ? ~bus.key_we : wr;
      bus.key_out <= want_z ? (bus.key_we ? bus.key_out : 16'h0000) : wr ? {hi, lo} : bus.key_out;
    end
  end
endmodule
